// File: rtl/tx_os_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tx_os_scheduler_pkg
//   Shared definitions for the TX ordered-set scheduler:
//     - ordered-set type encodings driven on os_type / ltssm_os_type
//     - scheduler FSM state enum
//     - ordered-set source enum (LTSSM request vs. periodic SKP)
//     - small decode helper for the FIFO data path
// -----------------------------------------------------------------------------
package tx_os_scheduler_pkg;

    // Ordered-set type encodings (3-bit)
    localparam logic [2:0] OS_TS1   = 3'd0;
    localparam logic [2:0] OS_TS2   = 3'd1;
    localparam logic [2:0] OS_SKP   = 3'd2;
    localparam logic [2:0] OS_EIOS  = 3'd3;
    localparam logic [2:0] OS_EIEOS = 3'd4;
    localparam logic [2:0] OS_FTS   = 3'd5;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Who asked for the ordered set currently in flight
    typedef enum logic {
        SRC_LTSSM = 1'b0,
        SRC_SKP   = 1'b1
    } os_src_t;

    // True when the FIFO owns the TX lane (mux on FIFO path, reads running)
    function automatic logic fifo_path_active(input state_t st);
        return (st == ST_DATA);
    endfunction

endpackage

// File: rtl/tx_skp_timer.sv
// -----------------------------------------------------------------------------
// tx_skp_timer
//   Counts cycles spent in the DATA state and raises skp_pending once a SKP
//   ordered set is due. The counter saturates while the SKP is waiting for a
//   packet boundary, and both counter and flag restart on the SKP launch.
//
// Parameters
//   SKP_INTERVAL : DATA cycles between SKP insertions
//   CNT_W        : counter width, 2**CNT_W must exceed SKP_INTERVAL
//
// Ports
//   pclk        in   TX clock
//   reset_n     in   asynchronous active-low reset
//   idle_clr    in   scheduler is idle: clear counter and flag
//   count_en    in   scheduler is in DATA: advance the counter
//   skp_launch  in   the SKP os_start pulse is issued on this edge
//   skp_pending out  SKP insertion due but not yet launched (registered)
// -----------------------------------------------------------------------------
module tx_skp_timer #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11
) (
    input  logic pclk,
    input  logic reset_n,
    input  logic idle_clr,
    input  logic count_en,
    input  logic skp_launch,
    output logic skp_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;

    // Next counter / pending value. The flag is raised on the same edge the
    // counter lands on its last value, so the SKP becomes eligible in the
    // SKP_INTERVAL-th DATA cycle.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (idle_clr || skp_launch) begin
            cnt_d     = CNT_ZERO;
            pending_d = 1'b0;
        end else if (count_en) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_d == CNT_LAST) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_q;
            end
        end else begin
            cnt_d     = cnt_q;
            pending_d = pending_q;
        end
    end

    // Counter and pending flag registers
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= CNT_ZERO;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign skp_pending = pending_q;

endmodule

// File: rtl/tx_os_scheduler.sv
// -----------------------------------------------------------------------------
// tx_os_scheduler
//   Decides when the TX lane carries FIFO data and when it carries an ordered
//   set, and launches the ordered-set generator. Ordered sets come either from
//   an LTSSM level request or from the periodic SKP timer; the LTSSM wins when
//   both are ready. In DATA, launches only happen at packet boundaries.
//
//   All outputs are registered. os_start is produced on the edge that enters
//   (or stays in) LAUNCH with os_busy low, so the pulse always lands inside a
//   LAUNCH cycle and the FSM moves to WAIT on the following edge.
//
// Build option
//   TX_SKP_INSERT_EN : defined   -> SKP timer (tx_skp_timer) and SKP launches
//                      undefined -> no timer, skp_pending tied low
//
// Parameters
//   SKP_INTERVAL : DATA cycles between SKP insertions (default 1180)
//   CNT_W        : SKP counter width, 2**CNT_W > SKP_INTERVAL (default 11)
//
// Ports
//   pclk          in   TX clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   ltssm_os_req  in   level request for one ordered set, held until done
//   ltssm_os_type in   [2:0] type for ltssm_os_req
//   data_mode     in   LTSSM in L0, FIFO path enabled
//   pkt_boundary  in   next FIFO word starts a packet, or FIFO empty
//   os_busy       in   ordered-set generator busy
//   os_finish     in   generator finished its last word (pulse)
//   os_start      out  launch pulse to the generator
//   os_type       out  [2:0] type presented with os_start, held to os_finish
//   mux_sel       out  1 = generator path, 0 = FIFO path
//   hold          out  stall FIFO read side
//   ltssm_os_done out  pulse after os_finish of an LTSSM-sourced set
//   skp_pending   out  SKP due but not yet launched
// -----------------------------------------------------------------------------
module tx_os_scheduler
    import tx_os_scheduler_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       ltssm_os_req,
    input  logic [2:0] ltssm_os_type,
    input  logic       data_mode,
    input  logic       pkt_boundary,
    input  logic       os_busy,
    input  logic       os_finish,
    output logic       os_start,
    output logic [2:0] os_type,
    output logic       mux_sel,
    output logic       hold,
    output logic       ltssm_os_done,
    output logic       skp_pending
);

    state_t     state_q;
    state_t     state_d;
    os_src_t    src_q;
    os_src_t    src_d;
    logic [2:0] os_type_q;
    logic [2:0] os_type_d;
    logic       os_start_q;
    logic       os_start_d;
    logic       mux_sel_q;
    logic       mux_sel_d;
    logic       hold_q;
    logic       hold_d;
    logic       ltssm_os_done_q;
    logic       ltssm_os_done_d;
    logic       skp_pending_s;

    // Next-state, source and type selection. Source and type are captured
    // only on entry to LAUNCH and then held through WAIT.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        os_type_d = os_type_q;
        case (state_q)
            ST_IDLE: begin
                if (ltssm_os_req) begin
                    state_d   = ST_LAUNCH;
                    src_d     = SRC_LTSSM;
                    os_type_d = ltssm_os_type;
                end else if (data_mode) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!data_mode) begin
                    state_d = ST_IDLE;
                end else if (pkt_boundary && ltssm_os_req) begin
                    state_d   = ST_LAUNCH;
                    src_d     = SRC_LTSSM;
                    os_type_d = ltssm_os_type;
                end else if (pkt_boundary && skp_pending_s) begin
                    state_d   = ST_LAUNCH;
                    src_d     = SRC_SKP;
                    os_type_d = OS_SKP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_LAUNCH: begin
                // Leave only after the pulse has actually been presented
                if (os_start_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_WAIT: begin
                if (os_finish) begin
                    if (data_mode) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered-output next values, derived from the state being entered
    always_comb begin
        os_start_d      = (state_d == ST_LAUNCH) && !os_busy;
        mux_sel_d       = !fifo_path_active(state_d);
        hold_d          = !fifo_path_active(state_d);
        ltssm_os_done_d = (state_q == ST_WAIT) && os_finish && (src_q == SRC_LTSSM);
    end

    // FSM state and output registers
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            src_q           <= SRC_LTSSM;
            os_type_q       <= OS_TS1;
            os_start_q      <= 1'b0;
            mux_sel_q       <= 1'b1;
            hold_q          <= 1'b1;
            ltssm_os_done_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            os_type_q       <= os_type_d;
            os_start_q      <= os_start_d;
            mux_sel_q       <= mux_sel_d;
            hold_q          <= hold_d;
            ltssm_os_done_q <= ltssm_os_done_d;
        end
    end

`ifdef TX_SKP_INSERT_EN
    logic skp_launch_s;
    logic idle_clr_s;
    logic count_en_s;

    // Timer controls: restart on the edge that issues the SKP os_start
    always_comb begin
        skp_launch_s = os_start_d && (src_d == SRC_SKP);
        idle_clr_s   = (state_q == ST_IDLE);
        count_en_s   = (state_q == ST_DATA);
    end

    tx_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_timer (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .idle_clr    (idle_clr_s),
        .count_en    (count_en_s),
        .skp_launch  (skp_launch_s),
        .skp_pending (skp_pending_s)
    );
`else
    assign skp_pending_s = 1'b0;
`endif

    assign os_start      = os_start_q;
    assign os_type       = os_type_q;
    assign mux_sel       = mux_sel_q;
    assign hold          = hold_q;
    assign ltssm_os_done = ltssm_os_done_q;
    assign skp_pending   = skp_pending_s;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_os_scheduler
//   Directed and randomized checks of the TX ordered-set scheduler. Expected
//   values come from the protocol rules: launch latency = 1 + busy cycles (+
//   boundary wait in DATA), done one cycle after os_finish, requested types
//   tracked in a queue, SKP due after SKP_INT DATA cycles.
// -----------------------------------------------------------------------------
module tb_tx_os_scheduler;

    localparam int SKP_INT = 16;

    logic       pclk = 1'b0;
    logic       reset_n;
    logic       ltssm_os_req;
    logic [2:0] ltssm_os_type;
    logic       data_mode;
    logic       pkt_boundary;
    logic       os_busy;
    logic       os_finish;
    logic       os_start;
    logic [2:0] os_type;
    logic       mux_sel;
    logic       hold;
    logic       ltssm_os_done;
    logic       skp_pending;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] exp_types[$];

    tx_os_scheduler #(
        .SKP_INTERVAL (SKP_INT),
        .CNT_W        (5)
    ) dut (
        .pclk          (pclk),
        .reset_n       (reset_n),
        .ltssm_os_req  (ltssm_os_req),
        .ltssm_os_type (ltssm_os_type),
        .data_mode     (data_mode),
        .pkt_boundary  (pkt_boundary),
        .os_busy       (os_busy),
        .os_finish     (os_finish),
        .os_start      (os_start),
        .os_type       (os_type),
        .mux_sel       (mux_sel),
        .hold          (hold),
        .ltssm_os_done (ltssm_os_done),
        .skp_pending   (skp_pending)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drop to IDLE (one cycle with data_mode low)
    task automatic goto_idle();
        data_mode    = 1'b0;
        ltssm_os_req = 1'b0;
        @(negedge pclk);
        chk("idle_mux", mux_sel, 1'b1);
        chk("idle_hold", hold, 1'b1);
        chk("idle_start", os_start, 1'b0);
    endtask

    // Through IDLE into DATA; returns at the first DATA cycle
    task automatic goto_data();
        goto_idle();
        data_mode    = 1'b1;
        pkt_boundary = 1'($urandom_range(0, 1));
        @(negedge pclk);
        chk("data_mux", mux_sel, 1'b0);
        chk("data_hold", hold, 1'b0);
    endtask

    // One LTSSM ordered set: request now, pbw cycles without packet boundary
    // (DATA only), b busy cycles, f WAIT cycles then os_finish. Returns at the
    // cycle where ltssm_os_done is expected.
    task automatic do_ltssm(input logic [2:0] t, input int b, input int f,
                            input int pbw, input bit dm);
        logic [2:0] et;
        data_mode     = dm;
        ltssm_os_req  = 1'b1;
        ltssm_os_type = t;
        os_busy       = (b > 0);
        os_finish     = 1'b0;
        exp_types.push_back(t);
        if (dm) begin
            pkt_boundary = (pbw == 0);
            for (int i = 1; i <= pbw; i++) begin
                @(negedge pclk);
                chk("nobnd_start", os_start, 1'b0);
                chk("nobnd_hold", hold, 1'b0);
                chk("nobnd_mux", mux_sel, 1'b0);
                if (i == pbw) pkt_boundary = 1'b1;
            end
        end else begin
            pkt_boundary = 1'($urandom_range(0, 1));
        end
        for (int i = 1; i <= b; i++) begin
            @(negedge pclk);
            chk("busy_start", os_start, 1'b0);
            chk("busy_mux", mux_sel, 1'b1);
            chk("busy_hold", hold, 1'b1);
            chk("busy_done", ltssm_os_done, 1'b0);
            os_finish = 1'($urandom_range(0, 1));
            if (i == b) os_busy = 1'b0;
        end
        @(negedge pclk);
        et = exp_types.pop_front();
        chk("launch_start", os_start, 1'b1);
        chk("launch_type", os_type, et);
        chk("launch_mux", mux_sel, 1'b1);
        chk("launch_done", ltssm_os_done, 1'b0);
        os_finish = 1'b0;
        os_busy   = 1'b1;
        for (int j = 1; j <= f; j++) begin
            @(negedge pclk);
            chk("wait_start", os_start, 1'b0);
            chk("wait_mux", mux_sel, 1'b1);
            chk("wait_hold", hold, 1'b1);
            chk("wait_type", os_type, t);
            chk("wait_done", ltssm_os_done, 1'b0);
            if (j == f) os_finish = 1'b1;
        end
        @(negedge pclk);
        chk("done_pulse", ltssm_os_done, 1'b1);
        chk("done_mux", mux_sel, !dm);
        chk("done_hold", hold, !dm);
        chk("done_start", os_start, 1'b0);
        os_finish    = 1'b0;
        ltssm_os_req = 1'b0;
        os_busy      = 1'b0;
    endtask

    // Cycle after done, with a stray os_finish that must be ignored
    task automatic post_check(input bit dm);
        os_finish = 1'b1;
        @(negedge pclk);
        chk("post_done", ltssm_os_done, 1'b0);
        chk("post_start", os_start, 1'b0);
        chk("post_mux", mux_sel, !dm);
        chk("post_hold", hold, !dm);
        os_finish = 1'b0;
    endtask

    initial begin
        int n_start;
        int n_pend;
        int n_stall;
        bit dm;
        logic [2:0] t;
        int b;
        int f;
        int pbw;

        reset_n       = 1'b0;
        ltssm_os_req  = 1'b0;
        ltssm_os_type = 3'd0;
        data_mode     = 1'b0;
        pkt_boundary  = 1'b0;
        os_busy       = 1'b0;
        os_finish     = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_start", os_start, 1'b0);
        chk("rst_type", os_type, 3'd0);
        chk("rst_mux", mux_sel, 1'b1);
        chk("rst_hold", hold, 1'b1);
        chk("rst_done", ltssm_os_done, 1'b0);
        chk("rst_skp", skp_pending, 1'b0);
        reset_n = 1'b1;
        @(negedge pclk);
        chk("idle0_mux", mux_sel, 1'b1);
        chk("idle0_start", os_start, 1'b0);

        // TS1 from IDLE, finish after 4 WAIT cycles
        do_ltssm(3'd0, 0, 4, 0, 1'b0);
        post_check(1'b0);

        // Generator busy for 5 cycles in LAUNCH
        do_ltssm(3'd5, 5, 2, 0, 1'b0);
        post_check(1'b0);

        // DATA with data_mode dropping: back to IDLE, no launch
        goto_data();
        data_mode    = 1'b0;
        pkt_boundary = 1'b1;
        @(negedge pclk);
        chk("drop_mux", mux_sel, 1'b1);
        chk("drop_start", os_start, 1'b0);
        @(negedge pclk);
        chk("drop_start2", os_start, 1'b0);

        // Randomized LTSSM traffic from IDLE and DATA
        for (int n = 0; n < 12; n++) begin
            dm  = 1'($urandom_range(0, 1));
            t   = 3'($urandom_range(0, 5));
            b   = $urandom_range(0, 4);
            f   = $urandom_range(1, 5);
            pbw = dm ? $urandom_range(0, 4) : 0;
            if (dm) goto_data();
            else goto_idle();
            do_ltssm(t, b, f, pbw, dm);
            post_check(dm);
        end

        // Reset during WAIT: immediate reset values, no done pulse
        goto_idle();
        ltssm_os_req  = 1'b1;
        ltssm_os_type = 3'd4;
        os_busy       = 1'b0;
        @(negedge pclk);
        chk("rw_launch", os_start, 1'b1);
        os_busy = 1'b1;
        @(negedge pclk);
        chk("rw_wait_mux", mux_sel, 1'b1);
        os_finish = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk("rw_start", os_start, 1'b0);
        chk("rw_type", os_type, 3'd0);
        chk("rw_mux", mux_sel, 1'b1);
        chk("rw_hold", hold, 1'b1);
        chk("rw_done", ltssm_os_done, 1'b0);
        chk("rw_skp", skp_pending, 1'b0);
        ltssm_os_req = 1'b0;
        os_busy      = 1'b0;
        @(negedge pclk);
        chk("rw_done2", ltssm_os_done, 1'b0);
        os_finish = 1'b0;
        reset_n   = 1'b1;
        // First post-reset cycle is IDLE: a fresh request launches next cycle
        do_ltssm(3'd3, 0, 2, 0, 1'b0);
        post_check(1'b0);

`ifdef TX_SKP_INSERT_EN
        // SKP after SKP_INT DATA cycles at packet boundaries
        goto_idle();
        data_mode    = 1'b1;
        pkt_boundary = 1'b1;
        os_busy      = 1'b0;
        for (int k = 0; k < SKP_INT; k++) begin
            @(negedge pclk);
            chk("skp_pre_start", os_start, 1'b0);
            chk("skp_pre_mux", mux_sel, 1'b0);
            chk("skp_pre_pend", skp_pending, (k >= SKP_INT - 1));
        end
        @(negedge pclk);
        chk("skp_start", os_start, 1'b1);
        chk("skp_type", os_type, 3'd2);
        chk("skp_clr", skp_pending, 1'b0);
        os_busy = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            chk("skp_wait_mux", mux_sel, 1'b1);
            chk("skp_wait_done", ltssm_os_done, 1'b0);
        end
        os_finish = 1'b1;
        @(negedge pclk);
        chk("skp_nodone", ltssm_os_done, 1'b0);
        chk("skp_back_mux", mux_sel, 1'b0);
        os_finish    = 1'b0;
        os_busy      = 1'b0;
        pkt_boundary = 1'b0;
        // SKP pending but no boundary for 10+ cycles
        for (int k = 1; k <= SKP_INT + 9; k++) begin
            @(negedge pclk);
            chk("skp_nb_start", os_start, 1'b0);
            chk("skp_nb_hold", hold, 1'b0);
            chk("skp_nb_pend", skp_pending, (k >= SKP_INT - 1));
            if (k == SKP_INT + 9) pkt_boundary = 1'b1;
        end
        @(negedge pclk);
        chk("skp_nb_launch", os_start, 1'b1);
        chk("skp_nb_type", os_type, 3'd2);
        @(negedge pclk);
        os_finish = 1'b1;
        @(negedge pclk);
        os_finish = 1'b0;
        chk("skp_nb_back", mux_sel, 1'b0);

        // SKP due and LTSSM request together: LTSSM first, SKP right after
        goto_idle();
        data_mode    = 1'b1;
        pkt_boundary = 1'b1;
        for (int k = 0; k < SKP_INT; k++) begin
            @(negedge pclk);
            chk("both_pre_start", os_start, 1'b0);
        end
        chk("both_pend", skp_pending, 1'b1);
        do_ltssm(3'd1, 0, 2, 0, 1'b1);
        chk("both_pend_kept", skp_pending, 1'b1);
        @(negedge pclk);
        chk("both_skp_start", os_start, 1'b1);
        chk("both_skp_type", os_type, 3'd2);
        chk("both_skp_clr", skp_pending, 1'b0);
        @(negedge pclk);
        os_finish = 1'b1;
        @(negedge pclk);
        os_finish = 1'b0;
        chk("both_nodone", ltssm_os_done, 1'b0);
        chk("both_back_mux", mux_sel, 1'b0);
`else
        // No SKP insertion without the timer, over 5000 DATA cycles
        goto_data();
        n_start = 0;
        n_pend  = 0;
        n_stall = 0;
        for (int k = 0; k < 5000; k++) begin
            pkt_boundary = 1'($urandom_range(0, 1));
            @(negedge pclk);
            if (os_start) n_start++;
            if (skp_pending) n_pend++;
            if (hold || mux_sel) n_stall++;
        end
        chk("noskp_starts", n_start, 0);
        chk("noskp_pending", n_pend, 0);
        chk("noskp_stalls", n_stall, 0);
`endif

        goto_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_os_scheduler.md
TX_OS_SCHEDULER -- requirements
Module: tx_os_scheduler

Interface
REQ-001 Parameter SKP_INTERVAL, default 1180, pclk cycles between SKP ordered-set insertions while in data mode.
REQ-002 Parameter CNT_W, default 11, SKP counter width; SHALL satisfy 2^CNT_W > SKP_INTERVAL.
REQ-003 pclk  in  1  TX clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 ltssm_os_req  in  1  level request for one ordered set from the LTSSM; held until ltssm_os_done.
REQ-006 ltssm_os_type  in  3  OS type for ltssm_os_req; stable while the request is held.
REQ-007 data_mode  in  1  LTSSM in L0; FIFO data path enabled.
REQ-008 pkt_boundary  in  1  next FIFO word starts a packet, or the FIFO is empty.
REQ-009 os_busy  in  1  OS generator busy.
REQ-010 os_finish  in  1  one-cycle pulse; OS generator completed its last word.
REQ-011 os_start  out  1  one-cycle pulse launching the OS generator.
REQ-012 os_type  out  3  OS type presented with os_start; held until os_finish.
REQ-013 mux_sel  out  1  1 = OS generator path, 0 = FIFO path.
REQ-014 hold  out  1  stall the FIFO read side.
REQ-015 ltssm_os_done  out  1  one-cycle pulse when an LTSSM-requested OS finishes.
REQ-016 skp_pending  out  1  SKP insertion due but not yet launched.

Function
REQ-017 FSM states: IDLE, DATA, LAUNCH, WAIT.
REQ-018 IDLE: mux_sel=1, hold=1; ltssm_os_req -> LAUNCH (LTSSM source); else data_mode -> DATA.
REQ-019 DATA: mux_sel=0, hold=0; data_mode=0 -> IDLE next cycle, with no launch in that cycle.
REQ-020 DATA with pkt_boundary=1: ltssm_os_req -> LAUNCH (LTSSM source); else skp_pending -> LAUNCH (SKP source, os_type=OS_SKP).
REQ-021 Simultaneous ltssm_os_req and skp_pending: LTSSM served first; skp_pending stays set.
REQ-022 LAUNCH: mux_sel=1, hold=1; os_start=1 for exactly one cycle, only when os_busy=0, then -> WAIT; while os_busy=1, remain in LAUNCH without pulsing.
REQ-023 WAIT: mux_sel=1, hold=1 until os_finish; os_finish -> DATA if data_mode, else IDLE.
REQ-024 ltssm_os_done SHALL pulse in the cycle after os_finish, LTSSM source only.
REQ-025 SKP counter increments every cycle in DATA and resets to 0 when an SKP launch occurs.
REQ-026 skp_pending sets when the counter reaches SKP_INTERVAL-1; the counter then saturates until the SKP launch.
REQ-027 skp_pending clears in the os_start cycle of the SKP launch.
REQ-028 In IDLE the counter and skp_pending are cleared.
REQ-029 os_finish outside WAIT is ignored; os_start SHALL never assert outside LAUNCH.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, counter 0, os_start=0, os_type=0, mux_sel=1, hold=1, ltssm_os_done=0, skp_pending=0.
REQ-031 Reset mid-LAUNCH or mid-WAIT abandons the OS without a done pulse; the first post-reset cycle is IDLE.

Configuration
REQ-032 Macro TX_SKP_INSERT_EN defined: SKP counter and insertion as specified above.
REQ-033 Macro TX_SKP_INSERT_EN undefined: no counter logic; skp_pending tied 0; only LTSSM-sourced launches occur.

Structure
REQ-034 A shared package holds OS type encodings (OS_TS1=0, OS_TS2=1, OS_SKP=2, OS_EIOS=3, OS_EIEOS=4, OS_FTS=5) and the FSM state enum.
REQ-035 One sub-module, tx_skp_timer (counter plus pending flag), instantiated only under TX_SKP_INSERT_EN; FSM stays in the top module.

Verification
REQ-036 Reset, data_mode=1, pkt_boundary=1, SKP_INTERVAL=16, os_busy=0 -> os_start with os_type=2 after 16 DATA cycles; mux_sel=1 from launch through os_finish.
REQ-037 ltssm_os_req=1 with type 0 in IDLE -> os_start next cycle; os_finish after 4 cycles -> ltssm_os_done one cycle later; FSM returns to IDLE (data_mode=0).
REQ-038 skp_pending=1 and ltssm_os_req rising in the same DATA cycle -> LTSSM OS first; SKP launched immediately after return to DATA.
REQ-039 skp_pending=1, pkt_boundary=0 for 10 cycles -> no os_start, hold=0; pkt_boundary=1 -> os_start next cycle.
REQ-040 os_busy=1 for 5 cycles in LAUNCH -> no os_start; single pulse the cycle after os_busy falls.
REQ-041 reset_n low during WAIT -> outputs at reset values within the same cycle; no ltssm_os_done pulse; build without TX_SKP_INSERT_EN shows no SKP over 5000 DATA cycles.
